// File: rtl/spi_flash_reader.sv
// SPI flash sequential reader: issues READ (0x03) + 24-bit address, then streams
// len_i bytes out over a valid/ready byte interface. SPI mode 0.
//
// state  | meaning
// IDLE   | cs high, waiting for start_i
// CMD    | shifting out the 0x03 opcode
// ADDR   | shifting out the 24-bit address
// DATA   | clocking bytes in from poci_i
// STALL  | byte complete but output register full; sck held low
// FINISH | all bytes clocked; waiting for the last handshake
module spi_flash_reader #(
   parameter int CLK_DIV   = 2,
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk_system_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic [23:0]          addr_i,
   input  logic [LEN_WIDTH-1:0] len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [7:0]           data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 sck_o,
   output logic                 cs_o,
   output logic                 pico_o,
   input  logic                 poci_i
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STALL, FINISH} state_t;

   state_t               state, state_nxt;
   logic [DIV_W-1:0]     div_cnt;
   logic [4:0]           bit_cnt;
   logic [31:0]          sr_out;
   logic [7:0]           sr_in;
   logic [LEN_WIDTH-1:0] cnt;
   logic                 pending;

   logic shifting, phase_end, group_end, load, hs, last;

   always_comb begin
      shifting  = (state == CMD) || (state == ADDR) || (state == DATA);
      phase_end = shifting && (div_cnt == '0);
      group_end = phase_end && sck_o && (bit_cnt == 5'd0);
      load      = pending && !valid_o;
      hs        = valid_o && ready_i;
      last      = (cnt == LEN_WIDTH'(1));
      state_nxt = state;
      case (state)
         IDLE:   if (start_i && (len_i != '0)) state_nxt = CMD;
         CMD:    if (group_end) state_nxt = ADDR;
         ADDR:   if (group_end) state_nxt = DATA;
         DATA: begin
            if (group_end) begin
               if (valid_o)   state_nxt = STALL;
               else if (last) state_nxt = FINISH;
            end
         end
         STALL:  if (!valid_o) state_nxt = last ? FINISH : DATA;
         FINISH: if (!pending && hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_system_i or negedge reset_n_i) begin
      if (!reset_n_i) state <= IDLE;
      else            state <= state_nxt;
   end

   always_ff @(posedge clk_system_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         data_o  <= 8'h00;
         valid_o <= 1'b0;
         sck_o   <= 1'b0;
         cs_o    <= 1'b1;
         pico_o  <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= 5'd0;
         sr_out  <= 32'h0;
         sr_in   <= 8'h00;
         cnt     <= '0;
         pending <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (hs) valid_o <= 1'b0;
         // load and hs are mutually exclusive: load only fires with valid_o low
         if (load) begin
            data_o  <= sr_in;
            valid_o <= 1'b1;
            cnt     <= cnt - LEN_WIDTH'(1);
            pending <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (len_i == '0) begin
                     done_o <= 1'b1;
                  end else begin
                     cs_o    <= 1'b0;
                     busy_o  <= 1'b1;
                     sck_o   <= 1'b0;
                     pico_o  <= 1'b0;   // MSB of the 0x03 opcode
                     sr_out  <= {8'h03, addr_i};
                     cnt     <= len_i;
                     div_cnt <= DIV_LOAD;
                     bit_cnt <= 5'd7;
                  end
               end
            end
            CMD, ADDR, DATA: begin
               if (phase_end) begin
                  div_cnt <= DIV_LOAD;
                  if (!sck_o) begin
                     sck_o <= 1'b1;
                     if (state == DATA) sr_in <= {sr_in[6:0], poci_i};
                  end else begin
                     sck_o  <= 1'b0;
                     sr_out <= {sr_out[30:0], 1'b0};
                     if ((state == DATA) || ((state == ADDR) && (bit_cnt == 5'd0)))
                        pico_o <= 1'b0;
                     else
                        pico_o <= sr_out[30];
                     if (bit_cnt != 5'd0) begin
                        bit_cnt <= bit_cnt - 5'd1;
                     end else begin
                        bit_cnt <= (state == CMD) ? 5'd23 : 5'd7;
                        if (state == DATA) pending <= 1'b1;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt - DIV_W'(1);
               end
            end
            FINISH: begin
               if (!pending) begin
                  cs_o <= 1'b1;
                  if (hs) begin
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader: two instances (CLK_DIV=2 and 1) against a
// behavioural SPI flash and a queue-based reference of expected bytes/commands.
module tb_spi_flash_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, start, ready;
   logic [23:0] addr;
   logic [15:0] len;
   int          sel;
   int          rdy_mode;

   wire start_a = start && (sel == 0);
   wire start_b = start && (sel == 1);

   logic       a_busy, a_done, a_valid, a_sck, a_cs, a_pico, a_poci;
   logic [7:0] a_data;
   logic       b_busy, b_done, b_valid, b_sck, b_cs, b_pico, b_poci;
   logic [7:0] b_data;

   spi_flash_reader #(.CLK_DIV(2), .LEN_WIDTH(16)) dut_a (
      .clk_system_i(clk), .reset_n_i(reset_n), .start_i(start_a), .addr_i(addr),
      .len_i(len), .busy_o(a_busy), .done_o(a_done), .data_o(a_data),
      .valid_o(a_valid), .ready_i(ready), .sck_o(a_sck), .cs_o(a_cs),
      .pico_o(a_pico), .poci_i(a_poci));

   spi_flash_reader #(.CLK_DIV(1), .LEN_WIDTH(16)) dut_b (
      .clk_system_i(clk), .reset_n_i(reset_n), .start_i(start_b), .addr_i(addr),
      .len_i(len), .busy_o(b_busy), .done_o(b_done), .data_o(b_data),
      .valid_o(b_valid), .ready_i(ready), .sck_o(b_sck), .cs_o(b_cs),
      .pico_o(b_pico), .poci_i(b_poci));

   wire       m_busy  = (sel == 1) ? b_busy  : a_busy;
   wire       m_done  = (sel == 1) ? b_done  : a_done;
   wire       m_valid = (sel == 1) ? b_valid : a_valid;
   wire       m_sck   = (sel == 1) ? b_sck   : a_sck;
   wire       m_cs    = (sel == 1) ? b_cs    : a_cs;
   wire [7:0] m_data  = (sel == 1) ? b_data  : a_data;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int s_cyc = 0;
   int rises = 0;
   int cs_low = 0;

   logic [7:0]  exp_q[$];
   logic [31:0] exp_cmd[$];
   int          exp_done[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: event not expected or timed out (t=%0t)", name, $time);
   endtask

   // Flash contents: the documented test pattern at 0x123456, a hash elsewhere.
   function automatic logic [7:0] flash_byte(input logic [23:0] a);
      case (a)
         24'h123456: return 8'hDE;
         24'h123457: return 8'hAD;
         24'h123458: return 8'hBE;
         24'h123459: return 8'hEF;
         default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
      endcase
   endfunction

   int          fcnt[2];
   logic [31:0] fsr[2];

   function automatic logic flash_poci(input int k, input logic [31:0] sr);
      logic [7:0] b;
      if (k < 32) return 1'b0;
      b = flash_byte(sr[23:0] + 24'((k - 32) / 8));
      return b[7 - ((k - 32) % 8)];
   endfunction

   assign a_poci = flash_poci(fcnt[0], fsr[0]);
   assign b_poci = flash_poci(fcnt[1], fsr[1]);

   task automatic flash_edge(input int i, input logic s, input logic p);
      if (!s) begin
         fcnt[i] = 0;
      end else begin
         if (fcnt[i] < 32) fsr[i] = {fsr[i][30:0], p};
         fcnt[i]++;
         if (fcnt[i] == 32) begin
            if (exp_cmd.size() == 0) fail_now("cmd_unexpected");
            else check("cmd_addr_stream", fsr[i], exp_cmd.pop_front());
         end else if (fcnt[i] > 32) begin
            check("pico_zero_in_data", p, 1'b0);
         end
      end
   endtask

   always @(posedge a_sck or negedge a_cs) flash_edge(0, a_sck, a_pico);
   always @(posedge b_sck or negedge b_cs) flash_edge(1, b_sck, b_pico);

   always @(posedge clk) cyc++;

   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       ready = 1'b1;
            1:       ready = ($urandom % 4) != 0;
            default: ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops expectations whenever the DUT presents a byte or a done.
   logic       prev_sck, prev_done, prev_vwait;
   logic [7:0] prev_data;
   int         mon_n;
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (m_sck && !prev_sck) rises++;
         if (!m_cs) cs_low++;
         if (prev_vwait && m_valid) check("data_hold", m_data, prev_data);
         if (m_valid && ready) begin
            if (exp_q.size() == 0) fail_now("byte_extra");
            else check("byte", m_data, exp_q.pop_front());
         end
         if (prev_done) check("done_pulse_width", m_done, 1'b0);
         if (m_done) begin
            if (exp_done.size() == 0) begin
               fail_now("done_unexpected");
            end else begin
               mon_n = exp_done.pop_front();
               check("sck_rises", rises, (mon_n == 0) ? 0 : 32 + 8 * mon_n);
               check("bytes_left", exp_q.size(), 0);
               check("cs_at_done", m_cs, 1'b1);
               check("busy_at_done", m_busy, 1'b0);
               if (mon_n == 0) begin
                  check("done_lat_len0", cyc - s_cyc, 0);
                  check("cs_low_len0", cs_low, 0);
               end
            end
         end
         prev_sck   <= m_sck;
         prev_done  <= m_done;
         prev_vwait <= m_valid && !ready;
         prev_data  <= m_data;
      end else begin
         prev_sck   <= 1'b0;
         prev_done  <= 1'b0;
         prev_vwait <= 1'b0;
         prev_data  <= 8'h00;
      end
   end

   // Called at posedge+1 with the selected instance idle.
   task automatic issue(input int s, input logic [23:0] a, input int n);
      sel    = s;
      addr   = a;
      len    = 16'(n);
      rises  = 0;
      cs_low = 0;
      if (n > 0) begin
         exp_cmd.push_back({8'h03, a});
         for (int i = 0; i < n; i++) exp_q.push_back(flash_byte(a + 24'(i)));
      end
      exp_done.push_back(n);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      s_cyc = cyc;
      addr  = 24'($urandom);
      len   = 16'($urandom);
   endtask

   task automatic flush();
      exp_q.delete();
      exp_cmd.delete();
      exp_done.delete();
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && exp_done.size() != 0; i++) @(negedge clk);
      if (exp_done.size() != 0) begin
         fail_now("done_timeout");
         flush();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid_lat(input int exp);
      for (int i = 0; i < 2000 && !m_valid; i++) @(negedge clk);
      check("first_valid_latency", cyc - s_cyc, exp);
   endtask

   task automatic reset_mid();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("rst_cs", m_cs, 1'b1);
      check("rst_sck", m_sck, 1'b0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_busy", m_busy, 1'b0);
      flush();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int r50;
   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      sel      = 0;
      rdy_mode = 0;
      addr     = 24'h0;
      len      = 16'h0;
      fcnt[0] = 0; fcnt[1] = 0;
      fsr[0] = 32'h0; fsr[1] = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_a", {a_sck, a_cs, a_pico, a_data, a_valid, a_busy, a_done}, {3'b010, 8'h00, 3'b000});
      check("reset_b", {b_sck, b_cs, b_pico, b_data, b_valid, b_busy, b_done}, {3'b010, 8'h00, 3'b000});
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic read, no backpressure
      issue(0, 24'h123456, 4);
      wait_valid_lat(80 * 2 + 1);
      wait_done(2000);

      // Backpressure after the first byte
      rdy_mode = 2;
      issue(0, 24'h123456, 3);
      wait_valid_lat(80 * 2 + 1);
      repeat (50) @(negedge clk);
      r50 = rises;
      repeat (50) @(negedge clk);
      check("stall_sck_low", m_sck, 1'b0);
      check("stall_cs_low", m_cs, 1'b0);
      check("stall_no_rises", rises, r50);
      rdy_mode = 0;
      wait_done(2000);

      // Zero-length request
      issue(0, 24'($urandom), 0);
      wait_done(20);

      // Start pulsed while busy is ignored
      issue(0, 24'h00A5C3, 2);
      repeat (30) @(posedge clk);
      #1;
      addr  = 24'h777777;
      len   = 16'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(2000);

      // Reset during ADDR, then a fresh transaction
      issue(0, 24'($urandom), 3);
      repeat (60) @(posedge clk);
      reset_mid();
      issue(0, 24'($urandom), 2);
      wait_done(2000);

      // Reset during STALL, then a fresh transaction
      rdy_mode = 2;
      issue(0, 24'($urandom), 3);
      wait_valid_lat(80 * 2 + 1);
      repeat (60) @(negedge clk);
      check("stall_valid_held", m_valid, 1'b1);
      reset_mid();
      rdy_mode = 0;
      issue(0, 24'($urandom), 1);
      wait_done(2000);

      // CLK_DIV = 1 instance
      issue(1, 24'($urandom), 2);
      wait_valid_lat(80 * 1 + 1);
      wait_done(2000);

      // Address wrap is the flash's business: bytes still counted correctly
      issue(1, 24'hFFFFFE, 4);
      wait_done(2000);

      // Randomized transactions with random backpressure
      rdy_mode = 1;
      for (int t = 0; t < 8; t++) begin
         issue(int'($urandom % 2), 24'($urandom), int'($urandom_range(1, 5)));
         wait_done(4000);
      end
      rdy_mode = 0;
      repeat (5) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
